// File: rtl/lram_line_reader_if.sv
// Pixel stream from the line RAM reader to the display scan-out.
// One beat moves when pix_valid and pix_ready are both high.
interface lram_line_reader_if #(
    parameter int unsigned PIX_W = 2
);
    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;
    logic             pix_first;
    logic             pix_last;
    logic             pix_even;

    modport master (
        output pix_valid, pix_data, pix_first, pix_last, pix_even,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_data, pix_first, pix_last, pix_even,
        output pix_ready
    );
endinterface

// File: rtl/lram_line_reader.sv
// Reads one captured line from the 4-slot line RAM and streams it,
// horizontally repeated H_SCALE times, through a 2-entry skid FIFO.
module lram_line_reader #(
    parameter int unsigned LINE_W  = 160,
    parameter int unsigned H_SCALE = 2,
    parameter int unsigned PIX_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r_row_inc,
    input  logic [7:0]            rrow,
    input  logic                  even_line,
    input  logic                  frame,
    output logic [9:0]            lram_ra,
    output logic                  lram_re,
    input  logic [PIX_W-1:0]      lram_do,
    lram_line_reader_if.master    pix,
    output logic                  line_done,
    output logic                  busy,
    output logic                  overrun
);
    localparam logic [7:0] LAST_COL = 8'(LINE_W - 1);
    localparam logic [8:0] COL_END  = 9'(LINE_W);
    localparam logic       REP_LAST = 1'(H_SCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t           state;
    logic [1:0]       slot;
    logic [7:0]       rcol;
    logic [7:0]       ocol;
    logic             rep;
    logic             inflight;
    logic             even_q;
    logic [PIX_W-1:0] fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_count;

    logic             valid_c;
    logic             accept_c;
    logic             rep_last_c;
    logic             pop_c;
    logic             last_beat_c;
    logic [2:0]       occ_c;
    logic             read_c;

    // Only the slot bits of the row index address the RAM.
    logic unused_rrow;
    assign unused_rrow = ^rrow[7:2];

    // Read credit counts this cycle's pop so the FIFO can refill without bubbles.
    always_comb begin
        valid_c     = (fifo_count != 2'd0);
        accept_c    = valid_c && pix.pix_ready;
        rep_last_c  = (rep == REP_LAST);
        pop_c       = accept_c && rep_last_c;
        last_beat_c = valid_c && (ocol == LAST_COL) && rep_last_c;
        occ_c       = 3'(fifo_count) + 3'(inflight) - 3'(pop_c);
        read_c      = (state == S_STREAM) && !frame
                      && ({1'b0, rcol} < COL_END) && (occ_c < 3'd2);
    end

    assign lram_re       = read_c;
    assign lram_ra       = {slot, rcol};
    assign pix.pix_valid = valid_c;
    assign pix.pix_data  = valid_c ? fifo_mem[rd_ptr] : '0;
    assign pix.pix_first = valid_c && (ocol == 8'd0) && (rep == 1'b0);
    assign pix.pix_last  = last_beat_c;
    assign pix.pix_even  = even_q;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            slot        <= 2'd0;
            rcol        <= 8'd0;
            ocol        <= 8'd0;
            rep         <= 1'b0;
            inflight    <= 1'b0;
            even_q      <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
            line_done   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            line_done <= 1'b0;
            overrun   <= 1'b0;
            if (frame) begin
                // Abort: drop buffered and returning data, request in this cycle is lost.
                state      <= S_IDLE;
                inflight   <= 1'b0;
                wr_ptr     <= 1'b0;
                rd_ptr     <= 1'b0;
                fifo_count <= 2'd0;
                rep        <= 1'b0;
            end else begin
                inflight <= read_c;
                if (read_c) begin
                    rcol <= rcol + 8'd1;
                end
                if (inflight) begin
                    fifo_mem[wr_ptr] <= lram_do;
                    wr_ptr           <= ~wr_ptr;
                end
                if (pop_c) begin
                    rd_ptr <= ~rd_ptr;
                    ocol   <= ocol + 8'd1;
                end
                fifo_count <= fifo_count + 2'(inflight) - 2'(pop_c);
                if (accept_c) begin
                    rep <= rep_last_c ? 1'b0 : rep + 1'b1;
                end

                case (state)
                    S_IDLE: begin
                        if (r_row_inc) begin
                            slot   <= rrow[1:0];
                            even_q <= even_line;
                            rcol   <= 8'd0;
                            ocol   <= 8'd0;
                            rep    <= 1'b0;
                            state  <= S_STREAM;
                        end
                    end
                    S_STREAM: begin
                        if (r_row_inc) begin
                            overrun <= 1'b1;
                        end
                        if (accept_c && last_beat_c) begin
                            line_done <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (r_row_inc) begin
                            overrun <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lram_line_reader.sv
// Directed bench for lram_line_reader: an H_SCALE=2 and an H_SCALE=1 instance
// share clock, reset, frame and pixel backpressure, each with its own line RAM.
module tb_lram_line_reader;
    localparam int unsigned LINE_W = 160;
    localparam int unsigned PIX_W  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       req_a = 1'b0, req_b = 1'b0;
    logic [7:0] rrow = 8'd0;
    logic       even_line = 1'b0, frame = 1'b0, pix_ready = 1'b0;

    logic [9:0] ra_a, ra_b;
    logic       re_a, re_b;
    logic [1:0] do_a = 2'd0, do_b = 2'd0;
    logic       done_a, done_b, busy_a, busy_b, ovr_a, ovr_b;

    lram_line_reader_if #(.PIX_W(PIX_W)) pa ();
    lram_line_reader_if #(.PIX_W(PIX_W)) pb ();
    assign pa.pix_ready = pix_ready;
    assign pb.pix_ready = pix_ready;

    lram_line_reader #(.LINE_W(LINE_W), .H_SCALE(2), .PIX_W(PIX_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .r_row_inc(req_a), .rrow(rrow), .even_line(even_line),
        .frame(frame), .lram_ra(ra_a), .lram_re(re_a), .lram_do(do_a), .pix(pa),
        .line_done(done_a), .busy(busy_a), .overrun(ovr_a)
    );

    lram_line_reader #(.LINE_W(LINE_W), .H_SCALE(1), .PIX_W(PIX_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .r_row_inc(req_b), .rrow(rrow), .even_line(even_line),
        .frame(frame), .lram_ra(ra_b), .lram_re(re_b), .lram_do(do_b), .pix(pb),
        .line_done(done_b), .busy(busy_b), .overrun(ovr_b)
    );

    // Slot 2 holds col mod 4; every other slot holds its complement.
    function automatic logic [1:0] ram_val(input int slot, input int col);
        return (slot == 2) ? 2'(col % 4) : 2'(3 - (col % 4));
    endfunction

    logic [1:0] mem [1024];
    always @(posedge clk) begin
        if (re_a) do_a <= mem[ra_a];
        if (re_b) do_b <= mem[ra_b];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    logic       s_re, s_valid, s_first, s_last, s_even, s_done, s_busy, s_ovr;
    logic [9:0] s_ra;
    logic [1:0] s_data;

    task automatic grab(input bit b);
        s_re    = b ? re_b : re_a;
        s_ra    = b ? ra_b : ra_a;
        s_valid = b ? pb.pix_valid : pa.pix_valid;
        s_data  = b ? pb.pix_data  : pa.pix_data;
        s_first = b ? pb.pix_first : pa.pix_first;
        s_last  = b ? pb.pix_last  : pa.pix_last;
        s_even  = b ? pb.pix_even  : pa.pix_even;
        s_done  = b ? done_b : done_a;
        s_busy  = b ? busy_b : busy_a;
        s_ovr   = b ? ovr_b  : ovr_a;
    endtask

    function automatic int out_vec();
        return int'({s_re, s_ra, s_valid, s_data, s_first, s_last, s_even, s_done, s_busy, s_ovr});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int st_beats, st_reads, st_done, st_first_re, st_first_valid, st_ovr_cyc, st_ovr_cnt;
    int st_err_data, st_err_addr, st_err_stab, st_err_out, st_err_even;

    // Issues a request in cycle 0, then observes cycles 1..max_cyc relative to it.
    task automatic stream(input bit b, input int hs, input int pct, input logic [1:0] slot,
                          input logic ev, input int max_cyc, input int ovr_at, input int stop_beat);
        int exp_col = 0, pops = 0, n;
        logic p_stall = 1'b0, p_first = 1'b0, p_last = 1'b0, p_even = 1'b0;
        logic [1:0] p_data = 2'd0;
        st_beats = 0; st_reads = 0; st_done = -1; st_first_re = -1; st_first_valid = -1;
        st_ovr_cyc = -1; st_ovr_cnt = 0;
        st_err_data = 0; st_err_addr = 0; st_err_stab = 0; st_err_out = 0; st_err_even = 0;
        tick();
        rrow = 8'(4 + int'(slot));
        even_line = ev;
        if (b) req_b = 1'b1; else req_a = 1'b1;
        pix_ready = ($urandom_range(99) < pct);
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            tick();
            req_a = 1'b0;
            req_b = 1'b0;
            if (st_beats == stop_beat) return;
            if (cyc == ovr_at) begin
                rrow = 8'd1;
                if (b) req_b = 1'b1; else req_a = 1'b1;
            end
            pix_ready = ($urandom_range(99) < pct);
            #1;
            grab(b);
            if (s_re) begin
                if (st_reads == 0) st_first_re = cyc;
                if (s_ra !== {slot, 8'(exp_col)}) st_err_addr++;
                exp_col++;
                st_reads++;
            end
            if (s_valid && st_first_valid < 0) st_first_valid = cyc;
            if (p_stall && !(s_valid && s_data === p_data && s_first === p_first
                             && s_last === p_last && s_even === p_even)) st_err_stab++;
            if (s_valid && s_even !== ev) st_err_even++;
            if (s_valid && pix_ready) begin
                n = st_beats;
                if (s_data !== ram_val(int'(slot), n / hs)) st_err_data++;
                if (s_first !== (n == 0)) st_err_data++;
                if (s_last !== (n == hs * int'(LINE_W) - 1)) st_err_data++;
                st_beats++;
                if ((n % hs) == hs - 1) pops++;
            end
            if (st_reads - pops > 2) st_err_out++;
            if (s_ovr) begin
                if (st_ovr_cnt == 0) st_ovr_cyc = cyc;
                st_ovr_cnt++;
            end
            p_stall = s_valid && !pix_ready;
            p_data = s_data; p_first = s_first; p_last = s_last; p_even = s_even;
            if (s_done) begin
                st_done = cyc;
                return;
            end
        end
    endtask

    initial begin
        int dones;
        for (int i = 0; i < 1024; i++) mem[i] = ram_val(i / 256, i % 256);

        // Reset values
        tick();
        grab(0);
        check("reset_outputs_a", out_vec(), 0);
        grab(1);
        check("reset_outputs_b", out_vec(), 0);
        rst_n = 1'b1;
        tick();

        // Basic line, H_SCALE=2, slot 2, no backpressure
        stream(0, 2, 100, 2'd2, 1'b0, 400, -1, -1);
        check("basic_first_re_cycle", st_first_re, 1);
        check("basic_first_valid_cycle", st_first_valid, 3);
        check("basic_line_done_cycle", st_done, 323);
        check("basic_beats", st_beats, 320);
        check("basic_reads", st_reads, 160);
        check("basic_data_errors", st_err_data, 0);
        check("basic_addr_errors", st_err_addr, 0);
        check("basic_even_errors", st_err_even, 0);
        check("basic_overruns", st_ovr_cnt, 0);

        // Back-to-back request plus an ignored second request at cycle 50
        stream(0, 2, 100, 2'd2, 1'b0, 400, 50, -1);
        check("ovr_first_re_cycle", st_first_re, 1);
        check("ovr_pulse_cycle", st_ovr_cyc, 51);
        check("ovr_pulse_count", st_ovr_cnt, 1);
        check("ovr_line_done_cycle", st_done, 323);
        check("ovr_beats", st_beats, 320);
        check("ovr_data_errors", st_err_data, 0);
        check("ovr_addr_errors", st_err_addr, 0);

        // Backpressure, ready 30% of cycles, back-to-back again
        stream(0, 2, 30, 2'd2, 1'b0, 5000, -1, -1);
        check("bp_first_re_cycle", st_first_re, 1);
        check("bp_done_seen", int'(st_done > 0), 1);
        check("bp_beats", st_beats, 320);
        check("bp_reads", st_reads, 160);
        check("bp_data_errors", st_err_data, 0);
        check("bp_addr_errors", st_err_addr, 0);
        check("bp_stability_errors", st_err_stab, 0);
        check("bp_outstanding_errors", st_err_out, 0);
        check("bp_overruns", st_ovr_cnt, 0);

        // H_SCALE=1 with even_line set
        stream(1, 1, 100, 2'd2, 1'b1, 400, -1, -1);
        check("h1_first_valid_cycle", st_first_valid, 3);
        check("h1_line_done_cycle", st_done, 163);
        check("h1_beats", st_beats, 160);
        check("h1_reads", st_reads, 160);
        check("h1_data_errors", st_err_data, 0);
        check("h1_even_errors", st_err_even, 0);
        check("h1_outstanding_errors", st_err_out, 0);

        // Frame abort at beat 100
        stream(0, 2, 100, 2'd2, 1'b0, 400, -1, 100);
        check("abort_reached_beat", st_beats, 100);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        #1;
        grab(0);
        check("abort_busy", int'(s_busy), 0);
        check("abort_pix_valid", int'(s_valid), 0);
        dones = int'(s_done);
        for (int i = 0; i < 4; i++) begin
            tick();
            grab(0);
            dones += int'(s_done);
        end
        check("abort_no_line_done", dones, 0);
        stream(0, 2, 100, 2'd2, 1'b0, 400, -1, -1);
        check("after_abort_first_re_cycle", st_first_re, 1);
        check("after_abort_line_done_cycle", st_done, 323);
        check("after_abort_data_errors", st_err_data, 0);
        check("after_abort_addr_errors", st_err_addr, 0);

        // Asynchronous reset at beat 200, then a line from slot 1
        stream(0, 2, 100, 2'd2, 1'b0, 400, -1, 200);
        check("rst_reached_beat", st_beats, 200);
        #1;
        rst_n = 1'b0;
        #1;
        grab(0);
        check("rst_outputs_zero", out_vec(), 0);
        tick();
        tick();
        rst_n = 1'b1;
        stream(0, 2, 100, 2'd1, 1'b0, 400, -1, -1);
        check("after_rst_line_done_cycle", st_done, 323);
        check("after_rst_beats", st_beats, 320);
        check("after_rst_data_errors", st_err_data, 0);
        check("after_rst_addr_errors", st_err_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
